slowram_shadow_ctrl: RTL and testbench

Sequencer for the 128 KB slow RAM (banks E0/E1, port A). It sees every CPU bus cycle and copies shadowed writes to banks 00/01 into E0/E1 through a small write FIFO. It serves direct CPU accesses to E0/E1 in fixed 1 MHz slots and drives `cpu_wait` whenever the CPU must stall for slow RAM.

---
 rtl/slowram_shadow_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_slowram_shadow_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/slowram_shadow_ctrl.sv
// Slow RAM (banks E0/E1) sequencer: mirrors shadowed bank 00/01 writes through a
// small FIFO and serves direct E0/E1 accesses in fixed slots, stalling the CPU as needed.
module slowram_shadow_ctrl #(
    parameter int SLOT_DIV   = 14,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        cpu_strobe,
    input  logic [7:0]  bank,
    input  logic [15:0] addr,
    input  logic [7:0]  dout,
    input  logic        we,
    input  logic        io,
    input  logic [7:0]  shadow,
    output logic        cpu_wait,
    output logic [16:0] slow_addr,
    output logic [7:0]  slow_din,
    output logic        slow_we,
    output logic        slow_ce,
    input  logic [7:0]  slow_dout,
    output logic [7:0]  rd_data,
    output logic        rd_valid,
    output logic [4:0]  fifo_level
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = (SLOT_DIV > 1) ? $clog2(SLOT_DIV) : 1;

    typedef enum logic [1:0] {IDLE, DWAIT, DACC, FULLWAIT} state_t;

    state_t        state, state_next;
    logic [CW-1:0] slot_cnt;
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [24:0]   fifo_mem [FIFO_DEPTH];
    logic          pending_valid;
    logic [24:0]   pending_data;
    logic [16:0]   req_addr;
    logic [7:0]    req_din;
    logic          req_we;
    logic [1:0]    acc_step;

    logic win_std, win_hi, is_direct, is_shadow;
    logic slot, fifo_full, pop, push_en;
    logic latch_req, push_strobe, push_pending, load_pending, issue_direct, capture;
    logic [24:0] push_data;
    logic unused_shadow_bits;

    assign unused_shadow_bits = ^shadow[7:6];

    // Address windows that mirror into slow RAM while their shadow bit is clear
    assign win_std = ((addr[15:10] == 6'b000001) && !shadow[0])
                   || ((addr[15:10] == 6'b000010) && !shadow[5])
                   || ((addr[15:13] == 3'b001) && !shadow[1])
                   || ((addr[15:13] == 3'b010) && !shadow[2]);
    assign win_hi  = (addr >= 16'h2000) && (addr <= 16'h9FFF) && !shadow[3];

    assign is_direct = cpu_strobe && !io && ((bank == 8'hE0) || (bank == 8'hE1));
    assign is_shadow = cpu_strobe && !io && we
                     && (((bank == 8'h00) && win_std)
                      || ((bank == 8'h01) && ((win_std && !shadow[4]) || win_hi)));

    assign slot      = (slot_cnt == '0);
    assign fifo_full = (fifo_level == 5'(FIFO_DEPTH));
    assign pop       = slot && (fifo_level != 5'd0);
    assign push_en   = push_strobe || push_pending;
    assign push_data = push_pending ? pending_data : {bank[0], addr, dout};

    always_comb begin
        state_next   = state;
        latch_req    = 1'b0;
        push_strobe  = 1'b0;
        push_pending = 1'b0;
        load_pending = 1'b0;
        issue_direct = 1'b0;
        capture      = 1'b0;
        case (state)
            IDLE: begin
                if (is_direct) begin
                    latch_req  = 1'b1;
                    state_next = DWAIT;
                end else if (is_shadow) begin
                    if (!fifo_full || pop) begin
                        push_strobe = 1'b1;
                    end else begin
                        load_pending = 1'b1;
                        state_next   = FULLWAIT;
                    end
                end
            end
            DWAIT: begin
                if (slot && (fifo_level == 5'd0) && !pending_valid) begin
                    issue_direct = 1'b1;
                    state_next   = DACC;
                end
            end
            // Step 0: slow_ce cycle; step 1: read data valid; step 2: rd_valid cycle
            DACC: begin
                case (acc_step)
                    2'd0:    if (req_we) state_next = IDLE;
                    2'd1:    capture = 1'b1;
                    default: state_next = IDLE;
                endcase
            end
            FULLWAIT: begin
                if (!fifo_full || pop) begin
                    push_pending = 1'b1;
                    state_next   = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (push_en) fifo_mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            cpu_wait      <= 1'b0;
            slot_cnt      <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            fifo_level    <= 5'd0;
            pending_valid <= 1'b0;
            pending_data  <= '0;
            req_addr      <= '0;
            req_din       <= '0;
            req_we        <= 1'b0;
            acc_step      <= 2'd0;
            slow_addr     <= '0;
            slow_din      <= '0;
            slow_we       <= 1'b0;
            slow_ce       <= 1'b0;
            rd_data       <= '0;
            rd_valid      <= 1'b0;
        end else begin
            state    <= state_next;
            cpu_wait <= (state_next != IDLE);
            slot_cnt <= (slot_cnt == CW'(SLOT_DIV - 1)) ? '0 : slot_cnt + CW'(1);
            acc_step <= (state == DACC) ? acc_step + 2'd1 : 2'd0;

            if (push_en) wr_ptr <= wr_ptr + PW'(1);
            if (pop)     rd_ptr <= rd_ptr + PW'(1);
            if (push_en && !pop)      fifo_level <= fifo_level + 5'd1;
            else if (pop && !push_en) fifo_level <= fifo_level - 5'd1;

            if (load_pending) begin
                pending_valid <= 1'b1;
                pending_data  <= {bank[0], addr, dout};
            end else if (push_pending) begin
                pending_valid <= 1'b0;
            end

            if (latch_req) begin
                req_addr <= {bank[0], addr};
                req_din  <= dout;
                req_we   <= we;
            end

            // Shadow writes own the slot; a direct access only gets a slot once the FIFO is dry
            slow_ce <= 1'b0;
            slow_we <= 1'b0;
            if (pop) begin
                slow_ce   <= 1'b1;
                slow_we   <= 1'b1;
                slow_addr <= fifo_mem[rd_ptr][24:8];
                slow_din  <= fifo_mem[rd_ptr][7:0];
            end else if (issue_direct) begin
                slow_ce   <= 1'b1;
                slow_we   <= req_we;
                slow_addr <= req_addr;
                slow_din  <= req_din;
            end

            rd_valid <= capture;
            if (capture) rd_data <= slow_dout;
        end
    end
endmodule

// File: tb/tb_slowram_shadow_ctrl.sv
// Directed self-checking bench for slowram_shadow_ctrl with a registered-read slow RAM model.
module tb_slowram_shadow_ctrl;
    localparam int SLOT_DIV   = 8;
    localparam int FIFO_DEPTH = 4;

    logic        clk_sys = 1'b0;
    logic        reset = 1'b1;
    logic        cpu_strobe = 1'b0;
    logic [7:0]  bank = 8'h00;
    logic [15:0] addr = 16'h0000;
    logic [7:0]  dout = 8'h00;
    logic        we = 1'b0;
    logic        io = 1'b0;
    logic [7:0]  shadow = 8'h00;
    logic        cpu_wait;
    logic [16:0] slow_addr;
    logic [7:0]  slow_din;
    logic        slow_we;
    logic        slow_ce;
    logic [7:0]  slow_dout = 8'h00;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic [4:0]  fifo_level;

    int checks = 0;
    int failures = 0;
    int edge_cnt;
    bit wait_seen = 1'b0;

    typedef struct {
        logic        we;
        logic [16:0] a;
        logic [7:0]  d;
        int          stamp;
    } acc_t;
    acc_t acc_q[$];

    logic [7:0] ram [0:131071];

    slowram_shadow_ctrl #(.SLOT_DIV(SLOT_DIV), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk_sys(clk_sys), .reset(reset), .cpu_strobe(cpu_strobe), .bank(bank),
        .addr(addr), .dout(dout), .we(we), .io(io), .shadow(shadow),
        .cpu_wait(cpu_wait), .slow_addr(slow_addr), .slow_din(slow_din),
        .slow_we(slow_we), .slow_ce(slow_ce), .slow_dout(slow_dout),
        .rd_data(rd_data), .rd_valid(rd_valid), .fifo_level(fifo_level)
    );

    always #5 clk_sys = ~clk_sys;

    always @(posedge clk_sys) begin
        if (slow_ce === 1'b1) begin
            if (slow_we) ram[slow_addr] <= slow_din;
            else         slow_dout <= ram[slow_addr];
        end
    end

    // Slot phase reference: the edge numbered k after reset release sees slot count k mod SLOT_DIV
    always @(posedge clk_sys or posedge reset) begin
        if (reset) edge_cnt <= 0;
        else       edge_cnt <= edge_cnt + 1;
    end

    always @(posedge clk_sys) begin
        acc_t e;
        #2;
        if (slow_ce === 1'b1) begin
            e.we = slow_we; e.a = slow_addr; e.d = slow_din; e.stamp = edge_cnt;
            acc_q.push_back(e);
        end
        if (cpu_wait === 1'b1) wait_seen = 1'b1;
    end

    task automatic cpu_cycle(input logic [7:0] b, input logic [15:0] a,
                             input logic [7:0] d, input logic w, input logic i);
        bank = b; addr = a; dout = d; we = w; io = i; cpu_strobe = 1'b1;
        @(negedge clk_sys);
        cpu_strobe = 1'b0; we = 1'b0; io = 1'b0;
    endtask

    task automatic run_cycles(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic align(input int p);
        for (int k = 0; k < 2 * SLOT_DIV && (edge_cnt % SLOT_DIV) != p; k++)
            @(negedge clk_sys);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(negedge clk_sys);
        reset = 1'b0;
        checks += 4;
        if (cpu_wait !== 1'b0) begin failures++; $display("[TB] FAIL reset_cpu_wait: got %b need 0", cpu_wait); end
        if (slow_ce !== 1'b0) begin failures++; $display("[TB] FAIL reset_slow_ce: got %b need 0", slow_ce); end
        if (fifo_level !== 5'd0) begin failures++; $display("[TB] FAIL reset_level: got %0d need 0", fifo_level); end
        if (rd_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_rd_valid: got %b need 0", rd_valid); end
    endtask

    task automatic test_shadow_copy;
        shadow = 8'h00;
        align(1);
        acc_q.delete(); wait_seen = 1'b0;
        cpu_cycle(8'h00, 16'h0400, 8'h5A, 1'b1, 1'b0);
        run_cycles(2 * SLOT_DIV);
        checks += 2;
        if (acc_q.size() != 1) begin failures++; $display("[TB] FAIL copy_count: got %0d need 1", acc_q.size()); end
        if (wait_seen) begin failures++; $display("[TB] FAIL copy_wait: cpu_wait seen high, need never"); end
        if (acc_q.size() >= 1) begin
            checks += 2;
            if ({acc_q[0].we, acc_q[0].a, acc_q[0].d} !== {1'b1, 17'h00400, 8'h5A}) begin
                failures++;
                $display("[TB] FAIL copy_write: got we=%b a=%h d=%h need we=1 a=00400 d=5a", acc_q[0].we, acc_q[0].a, acc_q[0].d);
            end
            if (acc_q[0].stamp % SLOT_DIV != 1) begin
                failures++; $display("[TB] FAIL copy_slot: got phase %0d need 1", acc_q[0].stamp % SLOT_DIV);
            end
        end
    endtask

    task automatic test_shadow_inhibit;
        logic [7:0]  v_sh [6] = '{8'h10, 8'h18, 8'h10, 8'h08, 8'h04, 8'h00};
        logic [7:0]  v_bk [6] = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h00, 8'h01};
        logic [15:0] v_ad [6] = '{16'h0400, 16'h2000, 16'h8000, 16'h8000, 16'h4000, 16'h0800};
        logic [7:0]  v_dt [6] = '{8'h11, 8'h33, 8'h22, 8'h44, 8'h55, 8'h66};
        bit          v_hit[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 6; i++) begin
            shadow = v_sh[i];
            align(1);
            acc_q.delete();
            cpu_cycle(v_bk[i], v_ad[i], v_dt[i], 1'b1, 1'b0);
            run_cycles(2 * SLOT_DIV);
            checks++;
            if (acc_q.size() != (v_hit[i] ? 1 : 0)) begin
                failures++; $display("[TB] FAIL inhibit_count[%0d]: got %0d need %0d", i, acc_q.size(), v_hit[i]);
            end else if (v_hit[i]) begin
                checks++;
                if ({acc_q[0].we, acc_q[0].a, acc_q[0].d} !== {1'b1, v_bk[i][0], v_ad[i], v_dt[i]}) begin
                    failures++;
                    $display("[TB] FAIL inhibit_write[%0d]: got a=%h d=%h need a=%h d=%h", i, acc_q[0].a, acc_q[0].d, {v_bk[i][0], v_ad[i]}, v_dt[i]);
                end
            end
        end
        shadow = 8'h00;
    endtask

    task automatic test_fifo_full;
        int n;
        logic [16:0] ea;
        shadow = 8'h00;
        align(1);
        acc_q.delete();
        for (int i = 0; i < 5; i++)
            cpu_cycle({7'h00, 1'(i)}, 16'h0400 + 16'(i), 8'hA0 + 8'(i), 1'b1, 1'b0);
        checks += 2;
        if (cpu_wait !== 1'b1) begin failures++; $display("[TB] FAIL full_wait_rise: got %b need 1", cpu_wait); end
        if (fifo_level !== 5'd4) begin failures++; $display("[TB] FAIL full_level: got %0d need 4", fifo_level); end
        n = 0;
        while (cpu_wait === 1'b1 && n < 4 * SLOT_DIV) begin n++; @(negedge clk_sys); end
        checks += 3;
        if (n != 3) begin failures++; $display("[TB] FAIL full_wait_len: got %0d cycles need 3", n); end
        if (slow_ce !== 1'b1) begin failures++; $display("[TB] FAIL full_wait_fall: slow_ce=%b need 1 when wait drops", slow_ce); end
        if (fifo_level !== 5'd4) begin failures++; $display("[TB] FAIL full_level_after: got %0d need 4", fifo_level); end
        run_cycles(5 * SLOT_DIV);
        checks++;
        if (acc_q.size() != 5) begin
            failures++; $display("[TB] FAIL full_count: got %0d need 5", acc_q.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                ea = {1'(i), 16'h0400 + 16'(i)};
                checks += 2;
                if ({acc_q[i].we, acc_q[i].a, acc_q[i].d} !== {1'b1, ea, 8'hA0 + 8'(i)}) begin
                    failures++; $display("[TB] FAIL full_order[%0d]: got a=%h d=%h need a=%h d=%h", i, acc_q[i].a, acc_q[i].d, ea, 8'hA0 + 8'(i));
                end
                if (acc_q[i].stamp - acc_q[0].stamp != i * SLOT_DIV) begin
                    failures++; $display("[TB] FAIL full_spacing[%0d]: got %0d need %0d", i, acc_q[i].stamp - acc_q[0].stamp, i * SLOT_DIV);
                end
            end
        end
    endtask

    task automatic test_read_after_write;
        int n;
        shadow = 8'h00;
        align(1);
        acc_q.delete();
        cpu_cycle(8'h00, 16'h0500, 8'hA5, 1'b1, 1'b0);
        cpu_cycle(8'hE0, 16'h0500, 8'h00, 1'b0, 1'b0);
        n = 0;
        while (rd_valid !== 1'b1 && n < 4 * SLOT_DIV) begin @(negedge clk_sys); n++; end
        checks += 3;
        if (rd_valid !== 1'b1) begin failures++; $display("[TB] FAIL raw_timeout: rd_valid=%b need 1", rd_valid); end
        if (rd_data !== 8'hA5) begin failures++; $display("[TB] FAIL raw_data: got %h need a5", rd_data); end
        if (cpu_wait !== 1'b1) begin failures++; $display("[TB] FAIL raw_wait_hold: got %b need 1", cpu_wait); end
        @(negedge clk_sys);
        checks += 3;
        if (rd_valid !== 1'b0) begin failures++; $display("[TB] FAIL raw_pulse: got %b need 0", rd_valid); end
        if (cpu_wait !== 1'b0) begin failures++; $display("[TB] FAIL raw_wait_fall: got %b need 0", cpu_wait); end
        if (acc_q.size() != 2) begin
            failures++; $display("[TB] FAIL raw_count: got %0d need 2", acc_q.size());
        end else begin
            checks += 2;
            if ({acc_q[0].we, acc_q[0].a, acc_q[1].we, acc_q[1].a} !== {1'b1, 17'h00500, 1'b0, 17'h00500}) begin
                failures++; $display("[TB] FAIL raw_order: got %b/%h then %b/%h need 1/00500 then 0/00500", acc_q[0].we, acc_q[0].a, acc_q[1].we, acc_q[1].a);
            end
            if (acc_q[1].stamp - acc_q[0].stamp != SLOT_DIV) begin
                failures++; $display("[TB] FAIL raw_slots: got gap %0d need %0d", acc_q[1].stamp - acc_q[0].stamp, SLOT_DIV);
            end
        end
    endtask

    task automatic test_min_latency;
        logic [2:0] seen;
        align(SLOT_DIV - 1);
        cpu_cycle(8'hE1, 16'h0800, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            seen[i] = rd_valid;
            @(negedge clk_sys);
        end
        seen = {rd_valid, seen[2:1]};
        checks += 2;
        if (seen !== 3'b100) begin failures++; $display("[TB] FAIL latency: rd_valid history %b need 100", seen); end
        if (rd_data !== 8'h66) begin failures++; $display("[TB] FAIL latency_data: got %h need 66", rd_data); end
        @(negedge clk_sys);
        checks++;
        if (cpu_wait !== 1'b0) begin failures++; $display("[TB] FAIL latency_wait: got %b need 0", cpu_wait); end
    endtask

    task automatic test_direct_write;
        int n;
        align(1);
        cpu_cycle(8'hE1, 16'h1234, 8'h3C, 1'b1, 1'b0);
        n = 0;
        while (slow_ce !== 1'b1 && n < 2 * SLOT_DIV) begin @(negedge clk_sys); n++; end
        checks += 2;
        if ({slow_ce, slow_we, slow_addr, slow_din} !== {2'b11, 17'h11234, 8'h3C}) begin
            failures++; $display("[TB] FAIL dwrite: got ce=%b we=%b a=%h d=%h need 1 1 11234 3c", slow_ce, slow_we, slow_addr, slow_din);
        end
        if (cpu_wait !== 1'b1) begin failures++; $display("[TB] FAIL dwrite_wait: got %b need 1", cpu_wait); end
        @(negedge clk_sys);
        checks += 2;
        if (cpu_wait !== 1'b0) begin failures++; $display("[TB] FAIL dwrite_wait_fall: got %b need 0", cpu_wait); end
        if (rd_valid !== 1'b0) begin failures++; $display("[TB] FAIL dwrite_rd_valid: got %b need 0", rd_valid); end
    endtask

    task automatic test_none_and_ignored;
        shadow = 8'h00;
        align(1);
        acc_q.delete(); wait_seen = 1'b0;
        cpu_cycle(8'hE1, 16'hC030, 8'h55, 1'b0, 1'b1);
        cpu_cycle(8'h02, 16'h0400, 8'h77, 1'b1, 1'b0);
        cpu_cycle(8'h00, 16'h0400, 8'h88, 1'b1, 1'b1);
        run_cycles(2 * SLOT_DIV);
        checks += 2;
        if (acc_q.size() != 0) begin failures++; $display("[TB] FAIL none_access: got %0d need 0", acc_q.size()); end
        if (wait_seen) begin failures++; $display("[TB] FAIL none_wait: cpu_wait seen high, need never"); end
        align(1);
        acc_q.delete();
        cpu_cycle(8'hE0, 16'h0500, 8'h00, 1'b0, 1'b0);
        checks++;
        if (cpu_wait !== 1'b1) begin failures++; $display("[TB] FAIL ignore_wait: got %b need 1", cpu_wait); end
        cpu_cycle(8'h00, 16'h0600, 8'h99, 1'b1, 1'b0);
        cpu_cycle(8'hE1, 16'h1234, 8'h00, 1'b0, 1'b0);
        checks++;
        if (fifo_level !== 5'd0) begin failures++; $display("[TB] FAIL ignore_level: got %0d need 0", fifo_level); end
        run_cycles(3 * SLOT_DIV);
        checks += 2;
        if (acc_q.size() != 1) begin
            failures++; $display("[TB] FAIL ignore_count: got %0d need 1", acc_q.size());
        end else if ({acc_q[0].we, acc_q[0].a} !== {1'b0, 17'h00500}) begin
            failures++; $display("[TB] FAIL ignore_count: got we=%b a=%h need 0 00500", acc_q[0].we, acc_q[0].a);
        end
        if (rd_data !== 8'hA5) begin failures++; $display("[TB] FAIL ignore_data: got %h need a5", rd_data); end
    endtask

    task automatic test_reset_mid;
        shadow = 8'h00;
        align(1);
        for (int i = 0; i < 3; i++)
            cpu_cycle(8'h00, 16'h0400 + 16'(i), 8'hC0 + 8'(i), 1'b1, 1'b0);
        cpu_cycle(8'hE0, 16'h0500, 8'h00, 1'b0, 1'b0);
        checks += 2;
        if (cpu_wait !== 1'b1) begin failures++; $display("[TB] FAIL rmid_pre_wait: got %b need 1", cpu_wait); end
        if (fifo_level !== 5'd3) begin failures++; $display("[TB] FAIL rmid_pre_level: got %0d need 3", fifo_level); end
        #2 reset = 1'b1;
        #1;
        checks += 3;
        if (cpu_wait !== 1'b0) begin failures++; $display("[TB] FAIL rmid_wait: got %b need 0", cpu_wait); end
        if (fifo_level !== 5'd0) begin failures++; $display("[TB] FAIL rmid_level: got %0d need 0", fifo_level); end
        if (slow_ce !== 1'b0) begin failures++; $display("[TB] FAIL rmid_ce: got %b need 0", slow_ce); end
        repeat (2) @(negedge clk_sys);
        reset = 1'b0;
        acc_q.delete();
        run_cycles(3 * SLOT_DIV);
        checks += 2;
        if (acc_q.size() != 0) begin failures++; $display("[TB] FAIL rmid_after: got %0d accesses need 0", acc_q.size()); end
        if (cpu_wait !== 1'b0) begin failures++; $display("[TB] FAIL rmid_after_wait: got %b need 0", cpu_wait); end
    endtask

    initial begin
        test_reset;
        test_shadow_copy;
        test_shadow_inhibit;
        test_fifo_full;
        test_read_after_write;
        test_min_latency;
        test_direct_write;
        test_none_and_ignored;
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
